// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Grants one word per client turn and holds the grant until the frame completes.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned WORD_LENGTH  = 8,
   parameter int unsigned NO_OF_WORDS  = 1,
   parameter int unsigned BUSY_TIMEOUT = 16,
   localparam int unsigned DW          = WORD_LENGTH * NO_OF_WORDS,
   localparam int unsigned GID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [DW-1:0]         tx_parallel_data_out,
   output logic                  tx_data_wr_enable_out,
   input  logic                  tx_busy_in,
   output logic [GID_W-1:0]      grant_id,
   output logic                  arb_busy,
   output logic                  timeout_error
);

   localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitBusy,
      StWaitDone
   } state_e;

   state_e             state_q, state_d;
   logic [GID_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic [DW-1:0]      data_q, data_d;
   logic               wr_q, wr_d;
   logic [GID_W-1:0]   gid_q, gid_d;
   logic               busy_q, busy_d;
   logic               tout_q, tout_d;

   logic               pick_found;
   logic [GID_W-1:0]   pick_idx;
   int unsigned        search_idx;
   logic [GID_W-1:0]   ptr_adv;

   // Search starts at ptr and wraps; the first valid client found wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      search_idx = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         search_idx = (32'(ptr_q) + k) % NUM_REQ;
         if (!pick_found && req_valid[search_idx]) begin
            pick_found = 1'b1;
            pick_idx   = GID_W'(search_idx);
         end
      end
   end

   assign ptr_adv = (32'(gid_q) == NUM_REQ - 1) ? '0 : gid_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ready_d = '0;
      data_d  = data_q;
      wr_d    = 1'b0;
      gid_d   = gid_q;
      tout_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (pick_found && !tx_busy_in) begin
               state_d = StIssue;
               data_d  = req_data[32'(pick_idx) * DW +: DW];
               gid_d   = pick_idx;
               ready_d = NUM_REQ'(1) << pick_idx;
               wr_d    = 1'b1;
            end
         end
         StIssue: begin
            state_d = StWaitBusy;
            cnt_d   = '0;
         end
         StWaitBusy: begin
            if (tx_busy_in) begin
               state_d = StWaitDone;
            end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
               // Word is already accepted, so the turn still moves on.
               tout_d  = 1'b1;
               state_d = StIdle;
               ptr_d   = ptr_adv;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWaitDone: begin
            if (!tx_busy_in) begin
               state_d = StIdle;
               ptr_d   = ptr_adv;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         cnt_q   <= '0;
         ready_q <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         gid_q   <= '0;
         busy_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
         tout_q  <= tout_d;
      end
   end

   assign req_ready             = ready_q;
   assign tx_parallel_data_out  = data_q;
   assign tx_data_wr_enable_out = wr_q;
   assign grant_id              = gid_q;
   assign arb_busy              = busy_q;
   assign timeout_error         = tout_q;

endmodule
